// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// PC source select values, default widths and the stage-control bundle.
package hazard_controller_pkg;

    localparam int HC_NUM_REGS       = 32;
    localparam int HC_REG_ADDR_WIDTH = 5;
    localparam int HC_PENDING_WIDTH  = 2;

    typedef enum logic [1:0] {
        HC_STATE_RUN         = 2'd0,
        HC_STATE_BRANCH_WAIT = 2'd1,
        HC_STATE_HALT        = 2'd2
    } hc_state_e;

    localparam logic PC_SRC_SEQ      = 1'b0;
    localparam logic PC_SRC_REDIRECT = 1'b1;

    // Every per-cycle pipeline control the controller drives.
    typedef struct packed {
        logic pc_wren;
        logic pc_src_redirect;
        logic if_id_wren;
        logic if_id_flush;
        logic id_ex_wren;
        logic id_ex_flush;
        logic ex_mem_wren;
        logic mem_wb_wren;
        logic ram_wren;
        logic reg_wren;
    } hc_ctrl_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the CPU datapath (master) and the hazard controller (slave):
// ID/WB instruction attributes and halt request in, stage controls out.
interface hazard_controller_if
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HC_REG_ADDR_WIDTH
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_address;
    logic                      id_rs1_used;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_address;
    logic                      id_rs2_used;
    logic [REG_ADDR_WIDTH-1:0] id_rd_address;
    logic                      id_reg_wren;
    logic                      id_is_control;
    logic                      wb_valid;
    logic                      wb_reg_wren;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_address;
    logic                      wb_is_control;
    logic                      halt_req;

    logic pc_wren;
    logic pc_src_redirect;
    logic if_id_wren;
    logic if_id_flush;
    logic id_ex_wren;
    logic id_ex_flush;
    logic ex_mem_wren;
    logic mem_wb_wren;
    logic ram_wren;
    logic reg_wren;
    logic busy;

    modport master (
        output id_valid, id_rs1_address, id_rs1_used, id_rs2_address, id_rs2_used,
               id_rd_address, id_reg_wren, id_is_control,
               wb_valid, wb_reg_wren, wb_rd_address, wb_is_control, halt_req,
        input  pc_wren, pc_src_redirect, if_id_wren, if_id_flush, id_ex_wren,
               id_ex_flush, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren, busy
    );

    modport slave (
        input  id_valid, id_rs1_address, id_rs1_used, id_rs2_address, id_rs2_used,
               id_rd_address, id_reg_wren, id_is_control,
               wb_valid, wb_reg_wren, wb_rd_address, wb_is_control, halt_req,
        output pc_wren, pc_src_redirect, if_id_wren, if_id_flush, id_ex_wren,
               id_ex_flush, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren, busy
    );
endinterface

// File: rtl/hazard_controller_reg_scoreboard.sv
// Per-register count of writes issued but not yet retired. Register 0 is
// never tracked. Counters hold rather than wrap; wrapping would be an
// upstream bug and is flagged by assertion.
module reg_scoreboard
    import hazard_controller_pkg::*;
#(
    parameter int NUM_REGS       = HC_NUM_REGS,
    parameter int REG_ADDR_WIDTH = HC_REG_ADDR_WIDTH,
    parameter int PENDING_WIDTH  = HC_PENDING_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc_en,
    input  logic [REG_ADDR_WIDTH-1:0] inc_addr,
    input  logic                      dec_en,
    input  logic [REG_ADDR_WIDTH-1:0] dec_addr,
    input  logic [REG_ADDR_WIDTH-1:0] lookup_a_addr,
    input  logic [REG_ADDR_WIDTH-1:0] lookup_b_addr,
    output logic                      lookup_a_pending,
    output logic                      lookup_b_pending,
    output logic                      any_pending
);
    logic [PENDING_WIDTH-1:0] pending_q [NUM_REGS];
    logic [PENDING_WIDTH-1:0] pending_d [NUM_REGS];
    logic                     overflow;
    logic                     underflow;

    // Next counter values: +1 on issue, -1 on retire, unchanged on both.
    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
        end
        pending_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (inc_en && inc_addr == REG_ADDR_WIDTH'(r) &&
                !(dec_en && dec_addr == REG_ADDR_WIDTH'(r))) begin
                if (pending_q[r] == '1) overflow = 1'b1;
                else pending_d[r] = pending_q[r] + PENDING_WIDTH'(1);
            end else if (dec_en && dec_addr == REG_ADDR_WIDTH'(r) &&
                         !(inc_en && inc_addr == REG_ADDR_WIDTH'(r))) begin
                if (pending_q[r] == '0) underflow = 1'b1;
                else pending_d[r] = pending_q[r] - PENDING_WIDTH'(1);
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) pending_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) pending_q[r] <= pending_d[r];
        end
    end

    // Flag illegal increments past the maximum or decrements below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!overflow);
            assert (!underflow);
        end
    end

    // Lookups and the aggregate pending flag.
    always_comb begin
        lookup_a_pending = (lookup_a_addr != '0) && (pending_q[lookup_a_addr] != '0);
        lookup_b_pending = (lookup_b_addr != '0) && (pending_q[lookup_b_addr] != '0);
        any_pending      = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (pending_q[r] != '0) any_pending = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage CPU: stalls ID on RAW hazards,
// serialises control flow until WB resolves the next PC, and freezes the
// whole pipeline on halt_req. Stage controls are combinational in the current
// state and ID/WB inputs so that a stall takes effect in the cycle it is seen.
// Optional macro HAZARD_CONTROLLER_PERF_EN adds stall/branch/halt cycle
// counters as extra outputs.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int NUM_REGS       = HC_NUM_REGS,
    parameter int REG_ADDR_WIDTH = HC_REG_ADDR_WIDTH,
    parameter int PENDING_WIDTH  = HC_PENDING_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave bus
`ifdef HAZARD_CONTROLLER_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_branch_cycles,
    output logic [31:0]        perf_halt_cycles
`endif
);
    hc_state_e state_q, state_d;
    hc_state_e ret_state_q, ret_state_d;
    hc_state_e eff_state;
    hc_ctrl_t  ctrl;
    logic      rs1_pending, rs2_pending, any_pending;
    logic      raw_hazard, issue, redirect_take, retire, inc_en;

    reg_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .PENDING_WIDTH  (PENDING_WIDTH)
    ) u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .inc_en           (inc_en),
        .inc_addr         (bus.id_rd_address),
        .dec_en           (retire),
        .dec_addr         (bus.wb_rd_address),
        .lookup_a_addr    (bus.id_rs1_address),
        .lookup_b_addr    (bus.id_rs2_address),
        .lookup_a_pending (rs1_pending),
        .lookup_b_pending (rs2_pending),
        .any_pending      (any_pending)
    );

    // While parked in HALT with halt_req already released, behave as the saved
    // state so the exit cycle does useful work (e.g. a pending redirect).
    always_comb begin
        eff_state     = (state_q == HC_STATE_HALT) ? ret_state_q : state_q;
        raw_hazard    = bus.id_valid &&
                        ((bus.id_rs1_used && rs1_pending) || (bus.id_rs2_used && rs2_pending));
        issue         = !bus.halt_req && eff_state == HC_STATE_RUN && bus.id_valid && !raw_hazard;
        redirect_take = !bus.halt_req && eff_state == HC_STATE_BRANCH_WAIT &&
                        bus.wb_valid && bus.wb_is_control;
        inc_en        = issue && bus.id_reg_wren && bus.id_rd_address != '0;
        retire        = bus.wb_valid && bus.wb_reg_wren && bus.wb_rd_address != '0 && ctrl.reg_wren;
    end

    // Stage controls for the current cycle.
    always_comb begin
        ctrl = '0;
        ctrl.pc_src_redirect = PC_SRC_SEQ;
        if (reset) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (!bus.halt_req) begin
            case (eff_state)
                HC_STATE_RUN: begin
                    ctrl.id_ex_wren  = 1'b1;
                    ctrl.ex_mem_wren = 1'b1;
                    ctrl.mem_wb_wren = 1'b1;
                    ctrl.ram_wren    = 1'b1;
                    ctrl.reg_wren    = 1'b1;
                    if (raw_hazard) begin
                        ctrl.id_ex_flush = 1'b1;
                    end else begin
                        ctrl.pc_wren    = !(issue && bus.id_is_control);
                        ctrl.if_id_wren = 1'b1;
                        ctrl.if_id_flush = issue && bus.id_is_control;
                    end
                end
                HC_STATE_BRANCH_WAIT: begin
                    ctrl.if_id_wren  = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_wren  = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    ctrl.ex_mem_wren = 1'b1;
                    ctrl.mem_wb_wren = 1'b1;
                    ctrl.ram_wren    = 1'b1;
                    ctrl.reg_wren    = 1'b1;
                    if (redirect_take) begin
                        ctrl.pc_wren         = 1'b1;
                        ctrl.pc_src_redirect = PC_SRC_REDIRECT;
                    end
                end
                default: ctrl = '0;
            endcase
        end
    end

    // Next state and the state to resume after a halt.
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        if (bus.halt_req) begin
            state_d = HC_STATE_HALT;
            if (state_q != HC_STATE_HALT) ret_state_d = state_q;
        end else begin
            case (eff_state)
                HC_STATE_RUN:         state_d = (issue && bus.id_is_control) ? HC_STATE_BRANCH_WAIT
                                                                             : HC_STATE_RUN;
                HC_STATE_BRANCH_WAIT: state_d = redirect_take ? HC_STATE_RUN : HC_STATE_BRANCH_WAIT;
                default:              state_d = HC_STATE_RUN;
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HC_STATE_RUN;
            ret_state_q <= HC_STATE_RUN;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
        end
    end

    assign bus.pc_wren         = ctrl.pc_wren;
    assign bus.pc_src_redirect = ctrl.pc_src_redirect;
    assign bus.if_id_wren      = ctrl.if_id_wren;
    assign bus.if_id_flush     = ctrl.if_id_flush;
    assign bus.id_ex_wren      = ctrl.id_ex_wren;
    assign bus.id_ex_flush     = ctrl.id_ex_flush;
    assign bus.ex_mem_wren     = ctrl.ex_mem_wren;
    assign bus.mem_wb_wren     = ctrl.mem_wb_wren;
    assign bus.ram_wren        = ctrl.ram_wren;
    assign bus.reg_wren        = ctrl.reg_wren;
    assign bus.busy            = !reset && (state_q != HC_STATE_RUN || any_pending);

`ifdef HAZARD_CONTROLLER_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_branch_q, perf_branch_d;
    logic [31:0] perf_halt_q, perf_halt_d;

    // Saturating cycle counters; a halted cycle counts only as halt.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_branch_d = perf_branch_q;
        perf_halt_d   = perf_halt_q;
        if (bus.halt_req) begin
            if (perf_halt_q != '1) perf_halt_d = perf_halt_q + 32'd1;
        end else if (eff_state == HC_STATE_BRANCH_WAIT) begin
            if (perf_branch_q != '1) perf_branch_d = perf_branch_q + 32'd1;
        end else if (eff_state == HC_STATE_RUN && raw_hazard) begin
            if (perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_branch_q <= '0;
            perf_halt_q   <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_branch_q <= perf_branch_d;
            perf_halt_q   <= perf_halt_d;
        end
    end

    assign perf_stall_cycles  = perf_stall_q;
    assign perf_branch_cycles = perf_branch_q;
    assign perf_halt_cycles   = perf_halt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: the bench owns a small instruction pipeline
// (IF/ID, EX, MEM, WB slots) that feeds the controller and predicts every
// control output from instruction-level rules.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_used;
        logic [4:0] rs2;
        logic       rs2_used;
        logic [4:0] rd;
        logic       wren;
        logic       ctrl;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_controller_if bus ();

`ifdef HAZARD_CONTROLLER_PERF_EN
    logic [31:0] perf_stall_cycles, perf_branch_cycles, perf_halt_cycles;
    int exp_stall, exp_branch, exp_halt;
    hazard_controller dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_branch_cycles (perf_branch_cycles),
        .perf_halt_cycles   (perf_halt_cycles)
    );
`else
    hazard_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    instr_t if_id, ex_s, mem_s, wb_s;
    instr_t fetch_q[$];
    logic   in_bw, halted_prev, rand_fetch;
    int     n_cmp, n_bad;
    int     obs_pc_low, obs_stall, obs_ifid_flush, obs_frozen, obs_redir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                  input logic u2, input logic [4:0] rd, input logic wr,
                                  input logic ct);
        instr_t i;
        i = '{valid: 1'b1, rs1: rs1, rs1_used: u1, rs2: rs2, rs2_used: u2,
              rd: rd, wren: wr, ctrl: ct};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(0, 99) < 85);
        i.rs1      = 5'($urandom_range(0, 7));
        i.rs1_used = ($urandom_range(0, 99) < 80);
        i.rs2      = 5'($urandom_range(0, 7));
        i.rs2_used = ($urandom_range(0, 99) < 60);
        i.rd       = 5'($urandom_range(0, 7));
        i.wren     = ($urandom_range(0, 99) < 70);
        i.ctrl     = ($urandom_range(0, 99) < 8);
        return i;
    endfunction

    function automatic instr_t fetch();
        if (fetch_q.size() > 0) return fetch_q.pop_front();
        if (rand_fetch) return rand_instr();
        return '0;
    endfunction

    // Writes to r still in flight = writers sitting in EX, MEM or WB.
    function automatic int pend(input logic [4:0] r);
        int n = 0;
        if (r == 5'd0) return 0;
        if (ex_s.valid  && ex_s.wren  && ex_s.rd  == r) n++;
        if (mem_s.valid && mem_s.wren && mem_s.rd == r) n++;
        if (wb_s.valid  && wb_s.wren  && wb_s.rd  == r) n++;
        return n;
    endfunction

    function automatic logic any_pend();
        for (int r = 1; r < 32; r++) if (pend(5'(r)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        if_id = '0; ex_s = '0; mem_s = '0; wb_s = '0;
        in_bw = 1'b0; halted_prev = 1'b0;
`ifdef HAZARD_CONTROLLER_PERF_EN
        exp_stall = 0; exp_branch = 0; exp_halt = 0;
`endif
    endtask

    task automatic drive(input logic halt);
        bus.id_valid       = if_id.valid;
        bus.id_rs1_address = if_id.rs1;
        bus.id_rs1_used    = if_id.rs1_used;
        bus.id_rs2_address = if_id.rs2;
        bus.id_rs2_used    = if_id.rs2_used;
        bus.id_rd_address  = if_id.rd;
        bus.id_reg_wren    = if_id.wren;
        bus.id_is_control  = if_id.ctrl;
        bus.wb_valid       = wb_s.valid;
        bus.wb_reg_wren    = wb_s.wren;
        bus.wb_rd_address  = wb_s.rd;
        bus.wb_is_control  = wb_s.ctrl;
        bus.halt_req       = halt;
    endtask

    function automatic logic [9:0] obs_vec();
        return {bus.pc_wren, bus.pc_src_redirect, bus.if_id_wren, bus.if_id_flush,
                bus.id_ex_wren, bus.id_ex_flush, bus.ex_mem_wren, bus.mem_wb_wren,
                bus.ram_wren, bus.reg_wren};
    endfunction

    task automatic clear_obs();
        obs_pc_low = 0; obs_stall = 0; obs_ifid_flush = 0; obs_frozen = 0; obs_redir = 0;
    endtask

    // One clock: drive from the model, check controls, then advance the model.
    task automatic step(input logic halt);
        logic hz, take, iss, exp_busy;
        logic [9:0] ev, ov;
        @(negedge clk);
        drive(halt);
        #1;
        hz   = if_id.valid && ((if_id.rs1_used && pend(if_id.rs1) != 0) ||
                               (if_id.rs2_used && pend(if_id.rs2) != 0));
        take = in_bw && wb_s.valid && wb_s.ctrl;
        iss  = !in_bw && if_id.valid && !hz;
        // bit order: pc, redirect, ifid_w, ifid_f, idex_w, idex_f, exmem, memwb, ram, reg
        if (halt)                  ev = 10'b0000000000;
        else if (in_bw)            ev = {take, take, 8'b11111111};
        else if (hz)               ev = 10'b0000111111;
        else if (iss && if_id.ctrl) ev = 10'b0011101111;
        else                       ev = 10'b1010101111;
        exp_busy = halted_prev || in_bw || any_pend();
        ov = obs_vec();
        check_eq("ctl", 32'(ov), 32'(ev));
        check_eq("busy", 32'(bus.busy), 32'(exp_busy));
        if (!bus.pc_wren) obs_pc_low++;
        if (!bus.pc_wren && bus.id_ex_flush && !bus.if_id_wren) obs_stall++;
        if (bus.if_id_flush) obs_ifid_flush++;
        if (ov == 10'd0) obs_frozen++;
        if (bus.pc_src_redirect) obs_redir++;
`ifdef HAZARD_CONTROLLER_PERF_EN
        if (halt) exp_halt++;
        else if (in_bw) exp_branch++;
        else if (hz) exp_stall++;
`endif
        if (halt) begin
            halted_prev = 1'b1;
        end else begin
            halted_prev = 1'b0;
            wb_s  = mem_s;
            mem_s = ex_s;
            if (in_bw) begin
                ex_s  = '0;
                if_id = '0;
                if (take) in_bw = 1'b0;
            end else if (hz) begin
                ex_s = '0;
            end else begin
                ex_s = if_id;
                if (iss && if_id.ctrl) begin
                    in_bw = 1'b1;
                    if_id = '0;
                end else begin
                    if_id = fetch();
                end
            end
        end
    endtask

    int halt_left;
    int guard;

    initial begin
        n_cmp = 0; n_bad = 0; halt_left = 0;
        rand_fetch = 1'b0;
        model_reset();
        clear_obs();
        reset = 1'b1;
        drive(1'b0);
        #1;
        check_eq("reset_ctl", 32'(obs_vec()), 32'(10'b0001010000));
        check_eq("reset_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,5 ; add x2,x1,x1 -> three stall cycles
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0));
        fetch_q.push_back(mk(5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0));
        clear_obs();
        repeat (8) step(1'b0);
        check_eq("raw_stall_len", 32'(obs_stall), 32'd3);

        // independent adds never stall
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0));
        fetch_q.push_back(mk(5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0));
        clear_obs();
        repeat (6) step(1'b0);
        check_eq("indep_pc_low", 32'(obs_pc_low), 32'd0);

        // taken branch: four flushed fetch cycles and one redirect
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1));
        clear_obs();
        repeat (8) step(1'b0);
        check_eq("br_ifid_flush", 32'(obs_ifid_flush), 32'd4);
        check_eq("br_redirect", 32'(obs_redir), 32'd1);

        // two writers of x7 then a reader
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0));
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0));
        fetch_q.push_back(mk(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0));
        clear_obs();
        repeat (10) step(1'b0);
        check_eq("x7_stall_len", 32'(obs_stall), 32'd3);

        // halt for five cycles during BRANCH_WAIT, then redirect completes
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1));
        guard = 0;
        while (!in_bw && guard < 10) begin
            step(1'b0);
            guard++;
        end
        check_eq("reach_bw", 32'(in_bw), 32'd1);
        step(1'b0);
        clear_obs();
        repeat (5) step(1'b1);
        check_eq("halt_frozen", 32'(obs_frozen), 32'd5);
        clear_obs();
        repeat (8) step(1'b0);
        check_eq("halt_redirect", 32'(obs_redir), 32'd1);

        // reset asserted in the middle of a RAW stall
        fetch_q.push_back(mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0));
        fetch_q.push_back(mk(5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0));
        repeat (4) step(1'b0);
        #2 reset = 1'b1;
        #1;
        check_eq("midreset_ctl", 32'(obs_vec()), 32'(10'b0001010000));
        check_eq("midreset_busy", 32'(bus.busy), 32'd0);
        fetch_q.delete();
        model_reset();
        drive(1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0);

        // randomized traffic with halt bursts
        rand_fetch = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (halt_left == 0 && $urandom_range(0, 99) < 3) halt_left = $urandom_range(1, 6);
            if (halt_left > 0) begin
                halt_left--;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end

`ifdef HAZARD_CONTROLLER_PERF_EN
        #1;
        check_eq("perf_stall", perf_stall_cycles, 32'(exp_stall));
        check_eq("perf_branch", perf_branch_cycles, 32'(exp_branch));
        check_eq("perf_halt", perf_halt_cycles, 32'(exp_halt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
